biquad_filter: RTL and testbench

Parametrised, time-multiplexed Direct Form I biquad IIR filter for the channel strip's filter section. It generalises the fixed 16-bit lowpass into one block covering lowpass, highpass, peaking and shelving responses through runtime-loadable coefficients. It serves NUM_CH audio channels through one serial multiply-accumulate datapath, and adds a click-free bypass mode. It sits between the audio input deserialiser and the dynamics stage, with a valid/ready handshake on its input and a valid strobe on its output.

---
 rtl/biquad_filter.sv | 205 ++++++++++++++++++++
 tb/tb_biquad_filter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_filter.sv
// biquad_filter
// Time-multiplexed Direct Form I biquad IIR filter shared by NUM_CH channels.
// One serial multiply-accumulate walks the five taps of the selected channel:
//     y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2
// The filter produces one sample per 7 clocks. Coefficients are shared by all
// channels and can be reloaded at run time through a shadow bank.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    input handshake; in_ch, in_data and bypass are
//                          captured on the accept edge
//   coef_we / coef_addr /  coefficient write into the shadow bank
//   coef_data              (0=b0 1=b1 2=b2 3=a1 4=a2, 5..7 ignored)
//   out_valid              one-cycle strobe qualifying out_ch / out_data / clip
//   clip                   filter result was saturated (never set in bypass)
module biquad_filter #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int FRAC   = 16,
    parameter int NUM_CH = 2,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bypass,
    input  logic              coef_we,
    input  logic [2:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_data,
    output logic              clip
);

    localparam int ACC_W = DATA_W + COEF_W + 3;
    localparam logic signed [COEF_W-1:0] COEF_ONE   = COEF_W'(1 << FRAC);
    localparam logic signed [ACC_W-1:0]  ROUND_HALF = ACC_W'(1) << (FRAC - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX    = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN    = ~SAT_MAX;
    localparam logic [CH_W:0]            NUM_CH_L   = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } stateType;

    stateType state;
    stateType nextState;

    logic signed [COEF_W-1:0] shadowCoef [5];
    logic signed [COEF_W-1:0] activeCoef [5];

    logic signed [DATA_W-1:0] x1Hist [NUM_CH];
    logic signed [DATA_W-1:0] x2Hist [NUM_CH];
    logic signed [DATA_W-1:0] y1Hist [NUM_CH];
    logic signed [DATA_W-1:0] y2Hist [NUM_CH];

    logic signed [DATA_W-1:0] xReg;
    logic [CH_W-1:0]          chReg;
    logic                     bypassReg;
    logic [2:0]               tap;
    logic signed [ACC_W-1:0]  acc;

    logic                     accept;
    logic                     chValid;
    logic [CH_W-1:0]          chIdx;
    logic signed [COEF_W-1:0] tapCoef;
    logic signed [DATA_W-1:0] tapSample;
    logic                     tapNegate;
    logic signed [ACC_W-1:0]  coefExt;
    logic signed [ACC_W-1:0]  sampleExt;
    logic signed [ACC_W-1:0]  product;
    logic signed [ACC_W-1:0]  accRound;
    logic signed [ACC_W-1:0]  accShift;
    logic                     satHi;
    logic                     satLo;
    logic signed [DATA_W-1:0] ySat;

    // Handshake: a sample is only taken while idle and out of reset.
    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    // Out-of-range channels still run through the datapath so latency is
    // unchanged, but history reads are steered to channel 0 and nothing is
    // written back or presented at the output.
    assign chValid = {1'b0, chReg} < NUM_CH_L;
    assign chIdx   = chValid ? chReg : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: one MAC cycle per tap, then a single output cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (in_valid) nextState = MAC;
            MAC:  if (tap == 3'd4) nextState = OUT;
            OUT:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Tap multiplexer: picks the coefficient/sample pair for the current tap.
    // Feedback taps are subtracted so a1/a2 carry their textbook sign.
    always_comb begin
        tapCoef   = '0;
        tapSample = '0;
        tapNegate = 1'b0;
        case (tap)
            3'd0: begin tapCoef = activeCoef[0]; tapSample = xReg;          end
            3'd1: begin tapCoef = activeCoef[1]; tapSample = x1Hist[chIdx]; end
            3'd2: begin tapCoef = activeCoef[2]; tapSample = x2Hist[chIdx]; end
            3'd3: begin tapCoef = activeCoef[3]; tapSample = y1Hist[chIdx]; tapNegate = 1'b1; end
            3'd4: begin tapCoef = activeCoef[4]; tapSample = y2Hist[chIdx]; tapNegate = 1'b1; end
            default: ;
        endcase
    end

    // Operands are sign-extended to the accumulator width so the low ACC_W bits
    // of the product are the exact signed product.
    assign coefExt   = {{(ACC_W - COEF_W){tapCoef[COEF_W-1]}}, tapCoef};
    assign sampleExt = {{(ACC_W - DATA_W){tapSample[DATA_W-1]}}, tapSample};
    assign product   = coefExt * sampleExt;

    // Round half up, drop the fractional bits, then saturate to the sample range.
    assign accRound = acc + ROUND_HALF;
    assign accShift = accRound >>> FRAC;
    assign satHi    = accShift > SAT_MAX;
    assign satLo    = accShift < SAT_MIN;
    assign ySat     = satHi ? SAT_MAX[DATA_W-1:0] :
                      satLo ? SAT_MIN[DATA_W-1:0] : accShift[DATA_W-1:0];

    // Datapath: coefficient banks, sample capture, accumulation, history and
    // the registered output. The active bank is refreshed from the shadow bank
    // only on the accept edge, so a write never disturbs a computation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                shadowCoef[i] <= (i == 0) ? COEF_ONE : '0;
                activeCoef[i] <= (i == 0) ? COEF_ONE : '0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                x1Hist[c] <= '0;
                x2Hist[c] <= '0;
                y1Hist[c] <= '0;
                y2Hist[c] <= '0;
            end
            xReg      <= '0;
            chReg     <= '0;
            bypassReg <= 1'b0;
            tap       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            clip      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            clip      <= 1'b0;

            if (coef_we && (coef_addr < 3'd5)) begin
                shadowCoef[coef_addr] <= coef_data;
            end

            if (accept) begin
                for (int i = 0; i < 5; i++) begin
                    activeCoef[i] <= shadowCoef[i];
                end
                xReg      <= in_data;
                chReg     <= in_ch;
                bypassReg <= bypass;
                tap       <= '0;
                acc       <= '0;
            end

            if (state == MAC) begin
                acc <= tapNegate ? (acc - product) : (acc + product);
                tap <= tap + 3'd1;
            end

            if ((state == OUT) && chValid) begin
                out_valid     <= 1'b1;
                out_ch        <= chReg;
                out_data      <= bypassReg ? xReg : ySat;
                clip          <= !bypassReg && (satHi || satLo);
                x2Hist[chIdx] <= x1Hist[chIdx];
                x1Hist[chIdx] <= xReg;
                y2Hist[chIdx] <= y1Hist[chIdx];
                y1Hist[chIdx] <= ySat;
            end
        end
    end

endmodule

// File: tb/tb_biquad_filter.sv
// tb_biquad_filter
// Directed bench for biquad_filter. Each sample goes through applyStimulus,
// which waits for in_ready, performs one accept, then watches nine clocks for
// the output strobe and compares count, latency, data, channel and clip
// against hand-computed values. The DUT is built with three channels so that
// a 2-bit channel port can carry an index that has no channel behind it.
module tb_biquad_filter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_ch = '0;
    logic [15:0] in_data = '0;
    logic        bypass = 1'b0;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [17:0] coef_data = '0;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] out_data;
    logic        clip;

    int total = 0;
    int bad = 0;

    bit          pendingWe = 1'b0;
    logic [2:0]  pendAddr = '0;
    logic [17:0] pendData = '0;

    biquad_filter #(
        .DATA_W(16),
        .COEF_W(18),
        .FRAC  (16),
        .NUM_CH(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ch    (in_ch),
        .in_data  (in_data),
        .bypass   (bypass),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .out_valid(out_valid),
        .out_ch   (out_ch),
        .out_data (out_data),
        .clip     (clip)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic writeCoef(input logic [2:0] addr, input int value);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = 18'(value);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One sample in, then watch E1..E9 for the output strobe.
    task automatic applyStimulus(input string tag, input logic [1:0] ch, input int data,
                                 input bit byp, input bit expValid, input int expData,
                                 input int expClip);
        int waitCyc = 0;
        int seen = 0;
        int latency = -1;
        int gotData = 0;
        int gotCh = 0;
        int gotClip = 0;
        @(negedge clk);
        while (!in_ready && waitCyc < 20) begin
            @(negedge clk);
            waitCyc++;
        end
        if (!in_ready) begin
            checkOutput({tag, ".readyTimeout"}, 0, 1);
            return;
        end
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = 16'(data);
        bypass   = byp;
        if (pendingWe) begin
            coef_we   = 1'b1;
            coef_addr = pendAddr;
            coef_data = pendData;
            pendingWe = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        bypass   = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen++;
                if (latency < 0) begin
                    latency = k;
                    gotData = int'($signed(out_data));
                    gotCh   = int'(out_ch);
                    gotClip = int'(clip);
                end
            end
        end
        if (expValid) begin
            checkOutput({tag, ".validCount"}, seen, 1);
            checkOutput({tag, ".latency"}, latency, 6);
            checkOutput({tag, ".data"}, gotData, expData);
            checkOutput({tag, ".ch"}, gotCh, int'(ch));
            checkOutput({tag, ".clip"}, gotClip, expClip);
        end else begin
            checkOutput({tag, ".noValid"}, seen, 0);
        end
    endtask

    initial begin
        int accCyc [3];
        int nAcc;
        int seen;

        $display("[TB] start");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        checkOutput("rst.out_valid", int'(out_valid), 0);
        checkOutput("rst.out_data", int'(out_data), 0);
        checkOutput("rst.out_ch", int'(out_ch), 0);
        checkOutput("rst.clip", int'(clip), 0);
        checkOutput("rst.in_ready", int'(in_ready), 1);

        // Identity after reset
        applyStimulus("ident", 2'd0, 1000, 1'b0, 1'b1, 1000, 0);

        // Throughput with in_valid held high
        @(negedge clk);
        nAcc = 0;
        in_valid = 1'b1;
        in_ch    = 2'd0;
        in_data  = 16'd1000;
        for (int cyc = 0; cyc < 30 && nAcc < 3; cyc++) begin
            if (in_ready) begin
                accCyc[nAcc] = cyc;
                nAcc++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("thru.accepts", nAcc, 3);
        checkOutput("thru.gap1", accCyc[1] - accCyc[0], 7);
        checkOutput("thru.gap2", accCyc[2] - accCyc[1], 7);

        // Coefficient write on the accept edge lands for the next sample
        pendingWe = 1'b1;
        pendAddr  = 3'd0;
        pendData  = 18'd32768;
        applyStimulus("weOnAccept", 2'd0, 1000, 1'b0, 1'b1, 1000, 0);
        applyStimulus("gainHalf", 2'd0, 32767, 1'b0, 1'b1, 16384, 0);
        applyStimulus("bypass", 2'd0, 20000, 1'b1, 1'b1, 20000, 0);

        // Saturation
        writeCoef(3'd0, 131071);
        applyStimulus("satPos", 2'd0, 32767, 1'b0, 1'b1, 32767, 1);
        applyStimulus("satNeg", 2'd0, -32768, 1'b0, 1'b1, -32768, 1);

        // Channel independence
        doReset();
        writeCoef(3'd0, 65536);
        writeCoef(3'd1, 65536);
        applyStimulus("chA", 2'd0, 100, 1'b0, 1'b1, 100, 0);
        applyStimulus("chB", 2'd1, 5, 1'b0, 1'b1, 5, 0);
        applyStimulus("chC", 2'd0, 0, 1'b0, 1'b1, 100, 0);
        applyStimulus("chBad", 2'd3, 1234, 1'b0, 1'b0, 0, 0);
        applyStimulus("chD", 2'd1, 0, 1'b0, 1'b1, 5, 0);

        // Recursion: y[n] = x[n] + 0.5*y[n-1]
        doReset();
        writeCoef(3'd0, 65536);
        writeCoef(3'd3, -32768);
        applyStimulus("rec0", 2'd0, 16384, 1'b0, 1'b1, 16384, 0);
        applyStimulus("rec1", 2'd0, 0, 1'b0, 1'b1, 8192, 0);
        applyStimulus("rec2", 2'd0, 0, 1'b0, 1'b1, 4096, 0);
        applyStimulus("rec3", 2'd0, 0, 1'b0, 1'b1, 2048, 0);

        // Reset at E3 aborts the sample and restores identity coefficients
        writeCoef(3'd0, 32768);
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = 2'd0;
        in_data  = 16'd777;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("abort.noValid", seen, 0);
        applyStimulus("abort.next", 2'd0, 500, 1'b0, 1'b1, 500, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
